// File: rtl/mips_cpu_state_sequencer.sv
// Multicycle fetch/decode/exec state register feeding the combinational MIPS controller.
// Optional waitrequest watchdog: define MIPS_CPU_WAITREQUEST_TIMEOUT_EN.
module mips_cpu_state_sequencer #(
  parameter logic [2:0] RESET_STATE    = 3'd1,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  fncode,
  input  logic [4:0]  regimm,
  input  logic        waitrequest,
  input  logic        muldiv_busy,
  input  logic [31:0] pc_next,
  output logic [2:0]  state,
  output logic        active,
  output logic        instr_retired,
  output logic [31:0] retired_count,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    S_HALTED = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4
  } state_t;

  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t state_q;
  state_t state_d;
  logic   mem_op;
  logic   muldiv_op;
  logic   two_cycle;
  logic   wait_stall;
  logic   busy_stall;
  logic   retire;
  logic   timeout_trip;

  assign mem_op     = opcode inside {[6'h20:6'h26], 6'h28, 6'h29, 6'h2b};
  assign muldiv_op  = (opcode == 6'h00) &&
                      (fncode inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b});
  assign two_cycle  = (opcode inside {[6'h20:6'h26]}) ||
                      ((opcode == 6'h01) && (regimm inside {5'h10, 5'h11}));
  assign wait_stall = waitrequest &&
                      ((state_q == S_FETCH) || ((state_q == S_EXEC1) && mem_op));
  assign busy_stall = (state_q == S_EXEC1) && muldiv_op && muldiv_busy;

  // Next-state selection; undefined opcodes fall through as single-exec-cycle NOPs.
  always_comb begin
    retire  = 1'b0;
    state_d = S_HALTED;
    case (state_q)
      S_HALTED: state_d = S_HALTED;
      S_FETCH:  state_d = waitrequest ? S_FETCH : S_DECODE;
      S_DECODE: state_d = S_EXEC1;
      S_EXEC1: begin
        if (wait_stall || busy_stall) begin
          state_d = S_EXEC1;
        end else if (two_cycle) begin
          state_d = S_EXEC2;
        end else begin
          retire = 1'b1;
        end
      end
      S_EXEC2:  retire = 1'b1;
      default:  state_d = S_HALTED;
    endcase
    if (retire) begin
      state_d = (pc_next == 32'h0000_0000) ? S_HALTED : S_FETCH;
    end
    if (timeout_trip) begin
      state_d = S_HALTED;
    end
  end

`ifdef MIPS_CPU_WAITREQUEST_TIMEOUT_EN
  logic [15:0] stall_cnt;
  logic [16:0] stall_cnt_inc;

  assign stall_cnt_inc = {1'b0, stall_cnt} + 17'd1;
  assign timeout_trip  = wait_stall && (stall_cnt_inc >= TIMEOUT_LIMIT);
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_LIMIT;
  assign timeout_trip   = 1'b0;
  assign bus_error      = 1'b0;
`endif

  // All outputs are registered so the controller never sees an input-driven glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= state_t'(RESET_STATE);
      active        <= 1'b1;
      instr_retired <= 1'b0;
      retired_count <= 32'h0;
`ifdef MIPS_CPU_WAITREQUEST_TIMEOUT_EN
      stall_cnt     <= 16'h0;
      bus_error     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      active        <= (state_d != S_HALTED);
      instr_retired <= retire;
      if (retire) begin
        retired_count <= retired_count + 32'd1;
      end
`ifdef MIPS_CPU_WAITREQUEST_TIMEOUT_EN
      stall_cnt <= wait_stall ? stall_cnt_inc[15:0] : 16'h0;
      if (timeout_trip) begin
        bus_error <= 1'b1;
      end
`endif
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Self-checking bench for mips_cpu_state_sequencer: an instruction-level model expands each
// instruction into expected per-cycle states, with randomized stalls and don't-care inputs.
module tb_mips_cpu_state_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  fncode;
  logic [4:0]  regimm;
  logic        waitrequest;
  logic        muldiv_busy;
  logic [31:0] pc_next;
  logic [2:0]  state;
  logic        active;
  logic        instr_retired;
  logic [31:0] retired_count;
  logic        bus_error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  st;
    logic        wr;
    logic        mb;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rg;
    logic [31:0] pc;
    logic        last;
  } cyc_t;

  cyc_t q[$];

  always #5 clk = ~clk;

  mips_cpu_state_sequencer #(.RESET_STATE(3'd1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .fncode(fncode), .regimm(regimm),
    .waitrequest(waitrequest), .muldiv_busy(muldiv_busy), .pc_next(pc_next),
    .state(state), .active(active), .instr_retired(instr_retired),
    .retired_count(retired_count), .bus_error(bus_error)
  );

  // Instruction classes written straight from the ISA groupings.
  function automatic bit model_mem(input logic [5:0] op);
    return (op >= 6'h20 && op <= 6'h26) || op == 6'h28 || op == 6'h29 || op == 6'h2b;
  endfunction

  function automatic bit model_muldiv(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn[5:4] == 2'b01) && (fn[2] == 1'b0);
  endfunction

  function automatic bit model_two(input logic [5:0] op, input logic [4:0] rg);
    return (op >= 6'h20 && op <= 6'h26) || (op == 6'h01 && (rg == 5'h10 || rg == 5'h11));
  endfunction

  function automatic logic [31:0] rand_pc();
    return ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
  endfunction

  // Expand one instruction into its expected cycles: fw fetch waits, xs exec stalls.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rg,
                           input int fw, input int xs, input bit halt);
    cyc_t c;
    bit mem = model_mem(op);
    bit md  = model_muldiv(op, fn);
    bit two = model_two(op, rg);
    logic [31:0] end_pc = halt ? 32'h0 : ($urandom | 32'h4);
    for (int i = 0; i <= fw; i++) begin
      c.st = 3'd1; c.wr = (i < fw); c.mb = 1'($urandom_range(0, 1));
      c.op = 6'($urandom); c.fn = 6'($urandom); c.rg = 5'($urandom);
      c.pc = rand_pc(); c.last = 1'b0;
      q.push_back(c);
    end
    c.op = op; c.fn = fn; c.rg = rg;
    c.st = 3'd2; c.wr = 1'($urandom_range(0, 1)); c.mb = 1'($urandom_range(0, 1));
    c.pc = rand_pc(); c.last = 1'b0;
    q.push_back(c);
    if (!(mem || md)) xs = 0;
    for (int i = 0; i < xs; i++) begin
      c.st = 3'd3; c.pc = rand_pc(); c.last = 1'b0;
      c.wr = mem ? 1'b1 : 1'($urandom_range(0, 1));
      c.mb = md ? 1'b1 : 1'($urandom_range(0, 1));
      q.push_back(c);
    end
    c.st = 3'd3;
    c.wr = mem ? 1'b0 : 1'($urandom_range(0, 1));
    c.mb = md ? 1'b0 : 1'($urandom_range(0, 1));
    c.last = !two;
    c.pc = two ? rand_pc() : end_pc;
    q.push_back(c);
    if (two) begin
      c.st = 3'd4; c.wr = 1'($urandom_range(0, 1)); c.mb = 1'($urandom_range(0, 1));
      c.pc = end_pc; c.last = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic add_random_instr();
    logic [5:0] op;
    logic [5:0] fn = 6'($urandom);
    logic [4:0] rg = 5'($urandom);
    case ($urandom_range(0, 8))
      0: begin op = 6'h00; fn = 6'h21; end
      1: op = 6'h09;
      2: op = 6'($urandom_range(32, 38));
      3: case ($urandom_range(0, 2)) 0: op = 6'h28; 1: op = 6'h29; default: op = 6'h2b; endcase
      4: begin op = 6'h01; rg = ($urandom_range(0, 1) == 1) ? 5'h11 : 5'h10; end
      5: begin op = 6'h01; rg = 5'($urandom_range(0, 15)); end
      6: begin op = 6'h00; fn = {2'b01, 1'($urandom_range(0, 1)), 1'b0, 2'($urandom)}; end
      7: case ($urandom_range(0, 3)) 0: op = 6'h3f; 1: op = 6'h27; 2: op = 6'h2a; default: op = 6'h13; endcase
      default: op = 6'h00;
    endcase
    add_instr(op, fn, rg, $urandom_range(0, 4), $urandom_range(0, 5), 1'b0);
  endtask

  task automatic drive_random();
    opcode = 6'($urandom); fncode = 6'($urandom); regimm = 5'($urandom);
    waitrequest = 1'($urandom_range(0, 1)); muldiv_busy = 1'($urandom_range(0, 1));
    pc_next = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_random();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_random();
    repeat (2) @(negedge clk);
    checks++;
    if ({state, active, instr_retired, bus_error} !== {3'd1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got state=%0d active=%b pulse=%b bus_error=%b, expected 1/1/0/0",
               state, active, instr_retired, bus_error);
    end
    checks++;
    if (retired_count !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_count: got %0d expected 0", retired_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_addiu_j();
    cyc_t c;
    logic [31:0] exp_cnt = 0;
    logic exp_pulse = 1'b0;
    do_reset();
    q.delete();
    add_instr(6'h09, 6'h00, 5'h00, 0, 0, 1'b0);
    add_instr(6'h02, 6'h00, 5'h00, 0, 0, 1'b1);
    while (q.size() > 0) begin
      c = q.pop_front();
      checks++;
      if ({state, active, instr_retired} !== {c.st, 1'b1, exp_pulse} || retired_count !== exp_cnt) begin
        failures++;
        $display("[TB] FAIL addiu_j_cycle: got state=%0d active=%b pulse=%b count=%0d, expected %0d/1/%b/%0d",
                 state, active, instr_retired, retired_count, c.st, exp_pulse, exp_cnt);
      end
      opcode = c.op; fncode = c.fn; regimm = c.rg;
      waitrequest = c.wr; muldiv_busy = c.mb; pc_next = c.pc;
      @(negedge clk);
      exp_pulse = c.last;
      if (c.last) exp_cnt++;
    end
    checks++;
    if ({state, active, instr_retired} !== {3'd0, 1'b0, 1'b1} || retired_count !== 32'd2) begin
      failures++;
      $display("[TB] FAIL addiu_j_halt: got state=%0d active=%b pulse=%b count=%0d, expected 0/0/1/2",
               state, active, instr_retired, retired_count);
    end
  endtask

  task automatic test_stream();
    cyc_t c;
    int cyc = 0;
    logic [31:0] exp_cnt = 0;
    logic exp_pulse = 1'b0;
    do_reset();
    q.delete();
    add_instr(6'h09, 6'h00, 5'h00, 1, 0, 1'b0);
    add_instr(6'h23, 6'h00, 5'h00, 0, 3, 1'b0);
    add_instr(6'h01, 6'h00, 5'h11, 0, 0, 1'b0);
    add_instr(6'h01, 6'h00, 5'h00, 2, 0, 1'b0);
    add_instr(6'h00, 6'h12, 5'h00, 0, 5, 1'b0);
    for (int i = 0; i < 40; i++) add_random_instr();
    add_instr(6'h02, 6'h00, 5'h00, 0, 0, 1'b1);
    while (q.size() > 0) begin
      c = q.pop_front();
      checks++;
      if (state !== c.st) begin
        failures++;
        $display("[TB] FAIL stream_state cycle %0d: got %0d expected %0d", cyc, state, c.st);
      end
      checks++;
      if ({active, instr_retired, bus_error} !== {1'b1, exp_pulse, 1'b0}) begin
        failures++;
        $display("[TB] FAIL stream_flags cycle %0d: got active=%b pulse=%b bus_error=%b, expected 1/%b/0",
                 cyc, active, instr_retired, bus_error, exp_pulse);
      end
      checks++;
      if (retired_count !== exp_cnt) begin
        failures++;
        $display("[TB] FAIL stream_count cycle %0d: got %0d expected %0d", cyc, retired_count, exp_cnt);
      end
      opcode = c.op; fncode = c.fn; regimm = c.rg;
      waitrequest = c.wr; muldiv_busy = c.mb; pc_next = c.pc;
      @(negedge clk);
      exp_pulse = c.last;
      if (c.last) exp_cnt++;
      cyc++;
    end
    // Halted must absorb every input combination except reset.
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({state, active, instr_retired} !== {3'd0, 1'b0, exp_pulse} || retired_count !== exp_cnt) begin
        failures++;
        $display("[TB] FAIL stream_halted %0d: got state=%0d active=%b pulse=%b count=%0d, expected 0/0/%b/%0d",
                 i, state, active, instr_retired, retired_count, exp_pulse, exp_cnt);
      end
      drive_random();
      @(negedge clk);
      exp_pulse = 1'b0;
    end
  endtask

  task automatic test_reset_mid_exec2();
    do_reset();
    opcode = 6'h09; fncode = 6'h00; regimm = 5'h00;
    waitrequest = 1'b0; muldiv_busy = 1'b0; pc_next = 32'h0000_0100;
    repeat (3) @(negedge clk);
    opcode = 6'h20;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd4 || retired_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL lb_exec2_reached: got state=%0d count=%0d expected 4/1", state, retired_count);
    end
    reset = 1'b1;
    pc_next = 32'h0;
    @(negedge clk);
    checks++;
    if ({state, active, instr_retired} !== {3'd1, 1'b1, 1'b0} || retired_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_exec2: got state=%0d active=%b pulse=%b count=%0d, expected 1/1/0/0",
               state, active, instr_retired, retired_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_stall_limit();
    do_reset();
    waitrequest = 1'b1;
`ifdef MIPS_CPU_WAITREQUEST_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (state !== 3'd1 || bus_error !== 1'b0) begin
        failures++;
        $display("[TB] FAIL timeout_pre %0d: got state=%0d bus_error=%b expected 1/0", i, state, bus_error);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({state, active, bus_error, instr_retired} !== {3'd0, 1'b0, 1'b1, 1'b0} || retired_count !== 32'd0) begin
        failures++;
        $display("[TB] FAIL timeout_trip %0d: got state=%0d active=%b bus_error=%b pulse=%b count=%0d, expected 0/0/1/0/0",
                 i, state, active, bus_error, instr_retired, retired_count);
      end
      waitrequest = 1'b0;
      @(negedge clk);
    end
`else
    for (int i = 0; i < 100; i++) begin
      checks++;
      if ({state, active, bus_error} !== {3'd1, 1'b1, 1'b0}) begin
        failures++;
        $display("[TB] FAIL stall_forever %0d: got state=%0d active=%b bus_error=%b expected 1/1/0",
                 i, state, active, bus_error);
      end
      @(negedge clk);
    end
`endif
    waitrequest = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    opcode = '0; fncode = '0; regimm = '0;
    waitrequest = 1'b0; muldiv_busy = 1'b0; pc_next = '0;
    test_reset();
    test_addiu_j();
    test_stream();
    test_reset_mid_exec2();
    test_stall_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
